// File: rtl/inst_axi_bridge_pkg.sv
// Shared constants and AR state encoding for the instruction-side AXI read bridge.
package inst_axi_bridge_pkg;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_t;

endpackage

// File: rtl/inst_axi_bridge_if.sv
// Fetch-side SRAM-like port and AXI3 read channels; the bridge is the sram slave and the axi master.
interface inst_sram_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );
    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

interface axi_rd_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/inst_axi_bridge_rbuf.sv
// Registered R-beat capture; data_ok pulses the cycle after a beat accepted while reads are outstanding.
module inst_bridge_rbuf (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_rvalid,
    input  logic [31:0] i_rdata,
    input  logic        i_cnt_nz,
    output logic        o_data_ok,
    output logic [31:0] o_rdata
);
    logic        r_data_ok;
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_ok <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_data_ok <= i_rvalid & i_cnt_nz;
            if (i_rvalid & i_cnt_nz) begin
                r_rdata <= i_rdata;
            end
        end
    end

    assign o_data_ok = r_data_ok;
    assign o_rdata   = r_rdata;
endmodule

// File: rtl/inst_axi_bridge.sv
// Instruction fetch to AXI3 single-beat read bridge with in-order outstanding-read credit.
// Optional sticky bridge_err output is built when INST_BRIDGE_ERR_EN is defined.
//
// state   | meaning
// AR_IDLE | may accept a fetch request (credit permitting)
// AR_SEND | arvalid held with latched address until arready
module inst_axi_bridge
    import inst_axi_bridge_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
`ifdef INST_BRIDGE_ERR_EN
    output logic       bridge_err,
`endif
    inst_sram_if.slave sram,
    axi_rd_if.master   axi
);
    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    ar_state_t        r_state;
    logic [31:0]      r_ar_addr;
    logic             r_arvalid;
    logic [CNT_W-1:0] r_cnt;

    logic w_addr_ok;
    logic w_r_beat;
    logic w_cnt_nz;
    logic w_cnt_dec;

    assign w_cnt_nz  = (r_cnt != '0);
    assign w_addr_ok = ~reset & (r_state == AR_IDLE) & sram.req & ~sram.wr & (r_cnt < CNT_MAX);
    assign w_r_beat  = axi.rvalid & axi.rready & axi.rlast;
    assign w_cnt_dec = w_r_beat & w_cnt_nz;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= AR_IDLE;
            r_arvalid <= 1'b0;
            r_ar_addr <= '0;
        end else begin
            case (r_state)
                AR_IDLE: begin
                    if (w_addr_ok) begin
                        r_ar_addr <= sram.addr;
                        r_arvalid <= 1'b1;
                        r_state   <= AR_SEND;
                    end
                end
                AR_SEND: begin
                    if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= AR_IDLE;
                    end
                end
            endcase
        end
    end

    // Accept and return in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            case ({w_addr_ok, w_cnt_dec})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    inst_bridge_rbuf u_rbuf (
        .clk       (clk),
        .reset     (reset),
        .i_rvalid  (w_r_beat),
        .i_rdata   (axi.rdata),
        .i_cnt_nz  (w_cnt_nz),
        .o_data_ok (sram.data_ok),
        .o_rdata   (sram.rdata)
    );

    assign sram.addr_ok = w_addr_ok;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = r_ar_addr;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = r_arvalid;
    assign axi.rready  = ~reset;

`ifdef INST_BRIDGE_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((w_r_beat & (axi.rresp != AXI_RESP_OKAY)) |
                     (axi.rvalid & axi.rready & ~w_cnt_nz) |
                     ((r_state == AR_IDLE) & sram.req & sram.wr)) begin
            r_err <= 1'b1;
        end
    end

    assign bridge_err = r_err;

    logic w_unused;
    assign w_unused = ^{sram.size, sram.wstrb, sram.wdata, axi.rid};
`else
    logic w_unused;
    assign w_unused = ^{sram.size, sram.wstrb, sram.wdata, axi.rid, axi.rresp};
`endif
endmodule
